// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the EX stage and the HI/LO multiply-divide unit
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        hilo_rd;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, srca, srcb, hilo_rd, flush, input busy, stall, done, hi, lo);
  modport slave (input start, op, srca, srcb, hilo_rd, flush, output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle iterative MULTU/DIVU with HI/LO registers and MTHI/MTLO writes
module muldiv_unit (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [63:0] work, work_n;
  logic [31:0] opa, hi, lo;
  logic        done, accept, fin, ge;
  logic [32:0] sum, r, diff;
  always_comb begin
    accept  = state == IDLE && bus.start && !bus.flush;
    fin     = state != IDLE && !bus.flush && cnt == 5'd31;
    sum     = {1'b0, work[63:32]} + (work[0] ? {1'b0, opa} : 33'd0);
    r       = {work[63:32], work[31]};
    diff    = r - {1'b0, opa};
    ge      = !diff[32];
    work_n  = state == MUL ? {sum, work[31:1]} : {ge ? diff[31:0] : r[31:0], work[30:0], ge};
    state_n = state == IDLE ? (accept && bus.op == 2'b00 ? MUL : accept && bus.op == 2'b01 ? DIV : IDLE)
                            : (bus.flush || cnt == 5'd31 ? IDLE : state);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt  <= '0;
      work <= '0;
      opa  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (accept && !bus.op[1]) begin
        cnt  <= '0;
        work <= {32'b0, bus.op[0] ? bus.srca : bus.srcb};
        opa  <= bus.op[0] ? bus.srcb : bus.srca;
      end
      if (accept && bus.op == 2'b10) hi <= bus.srca;
      if (accept && bus.op == 2'b11) lo <= bus.srca;
      if (state != IDLE) begin
        cnt  <= cnt + 5'd1;
        work <= work_n;
      end
      if (fin) {hi, lo} <= work_n;
    end
  assign bus.busy  = state != IDLE;
  assign bus.stall = bus.busy && (bus.hilo_rd || bus.start);
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o == 2'b00) return 64'(a) * 64'(b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction
  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'b00; bus.srca = '0; bus.srcb = '0; bus.hilo_rd = 1'b0; bus.flush = 1'b0;
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit hrd, input bit poke);
    logic [63:0] prev, e;
    int nb;
    bit got, changed;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.srca = a; bus.srcb = b; bus.hilo_rd = hrd;
    exp_q.push_back(model(o, a, b));
    prev = {bus.hi, bus.lo};
    @(negedge clk);
    bus.start = 1'b0; bus.srca = ~a; bus.srcb = ~b;
    nb = 0; got = 0; changed = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      bus.start = poke && i == 5;
      bus.op = poke && i == 5 ? 2'b10 : o;
      #1;
      if (bus.done) got = 1;
      else begin
        if (bus.busy) nb++;
        if ({bus.hi, bus.lo} !== prev) changed = 1;
        if (hrd || (poke && i == 5)) begin
          n_cmp++;
          if (bus.stall !== 1'b1) begin n_err++; $display("FAIL stall_busy i=%0d got=%b want=1", i, bus.stall); end
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL done_timeout op=%0d got=0 want=1", o); return; end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
    n_cmp++;
    if ({bus.hi, bus.lo} !== e) begin n_err++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", o, a, b, {bus.hi, bus.lo}, e); end
    n_cmp++;
    if (nb !== 32) begin n_err++; $display("FAIL busy_cycles got=%0d want=32", nb); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_in_done got=%b want=0", bus.busy); end
    n_cmp++;
    if (changed) begin n_err++; $display("FAIL partial_visible got=1 want=0"); end
    if (hrd) begin
      n_cmp++;
      if (bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_done got=%b want=0", bus.stall); end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_width got=%b want=0", bus.done); end
    bus.hilo_rd = 1'b0;
  endtask
  task automatic mt(input logic [1:0] o, input logic [31:0] d, input bit fl);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.srca = d; bus.flush = fl;
  endtask
  task automatic test_reset();
    idle_inputs();
    #12;
    n_cmp++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stall} !== 67'd0) begin
      n_err++; $display("FAIL reset_state got=%h/%h/%b/%b/%b want=0", bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_mul();
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    do_op(2'b00, 32'h8000_0001, 32'd3, 1'b0, 1'b0);
  endtask
  task automatic test_div();
    do_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0);
    do_op(2'b01, 32'd5, 32'd0, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b01, 32'd3, 32'h8000_0000, 1'b0, 1'b0);
  endtask
  task automatic test_mthi_mtlo();
    bit bad;
    bad = 0;
    mt(2'b10, 32'hDEAD_BEEF, 1'b0);
    mt(2'b11, 32'h1234_5678, 1'b0);
    #1 bad = bus.busy || bus.done;
    @(negedge clk);
    bus.start = 1'b0;
    bad = bad || bus.busy || bus.done;
    n_cmp++;
    if ({bus.hi, bus.lo} !== 64'hDEAD_BEEF_1234_5678) begin n_err++; $display("FAIL mthi_mtlo got=%h want=deadbeef12345678", {bus.hi, bus.lo}); end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL mt_busy_done got=1 want=0"); end
    mt(2'b10, 32'h5555_5555, 1'b1);
    mt(2'b00, 32'h7, 1'b1);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    n_cmp++;
    if ({bus.hi, bus.lo, bus.busy} !== {64'hDEAD_BEEF_1234_5678, 1'b0}) begin
      n_err++; $display("FAIL flush_start got=%h busy=%b want=deadbeef12345678 busy=0", {bus.hi, bus.lo}, bus.busy);
    end
  endtask
  task automatic test_stall();
    do_op(2'b00, 32'hCAFE_F00D, 32'h0BAD_1DEA, 1'b1, 1'b1);
    do_op(2'b01, 32'h7654_3210, 32'd1000, 1'b0, 1'b1);
  endtask
  task automatic test_flush();
    bit sawd;
    mt(2'b10, 32'd3, 1'b0);
    mt(2'b11, 32'd4, 1'b0);
    mt(2'b01, 32'd1000, 1'b0);
    bus.srcb = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'd3, 32'd4}) begin
      n_err++; $display("FAIL flush_abort busy=%b hi=%h lo=%h want busy=0 hi=3 lo=4", bus.busy, bus.hi, bus.lo);
    end
    sawd = 0;
    for (int i = 0; i < 30; i++) begin
      sawd = sawd || bus.done;
      @(negedge clk);
    end
    n_cmp++;
    if (sawd || {bus.hi, bus.lo} !== {32'd3, 32'd4}) begin n_err++; $display("FAIL flush_no_done done_seen=%b hi=%h lo=%h", sawd, bus.hi, bus.lo); end
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.srca = 32'h1111_1111; bus.srcb = 32'h2222_2222;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
      n_err++; $display("FAIL async_reset hi=%h lo=%h busy=%b done=%b want all 0", bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b1;
    do_op(2'b00, 32'd12345, 32'd6789, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_op(2'(i & 1), $urandom, i == 4 ? 32'd0 : $urandom, i[1], 1'b0);
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_mthi_mtlo();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  EX-stage request, sampled only in IDLE
- op  in  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- srca  in  32  multiplicand / dividend / MTHI-MTLO data
- srcb  in  32  multiplier / divisor
- hilo_rd  in  1  decode stage holds MFHI/MFLO
- flush  in  1  pipeline flush; aborts an operation in progress
- busy  out  1  iterative operation in progress
- stall  out  1  pipeline stall request
- done  out  1  one-cycle pulse, new HI/LO visible
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-002 The block SHALL implement FSM states IDLE, MUL and DIV, with a 5-bit iteration counter and a 64-bit working register.
- IDLE -> MUL: start=1, op=00, flush=0.
- IDLE -> DIV: start=1, op=01, flush=0.
- MUL/DIV -> IDLE: after the 32nd iteration edge, or on flush.
REQ-003 MTHI/MTLO SHALL write srca into hi/lo at the edge sampling start=1 in IDLE, with no state change and no done pulse.
REQ-004 Unsigned multiply SHALL use shift-add, one multiplier bit per cycle:
- at the accept edge, working register = {32'b0, srcb}, multiplicand latched from srca;
- per iteration, if bit 0 = 1, add the multiplicand to the upper 32 bits (33-bit sum, carry kept); then shift the working register right by 1;
- final {hi, lo} = srca*srcb, full 64 bits.
REQ-005 Unsigned divide SHALL use the restoring method, one quotient bit per iteration:
- lo = quotient, hi = remainder;
- divisor 0 SHALL need no special-casing and yields lo=32'hFFFF_FFFF, hi=srca.
REQ-006 Latency for a start accepted at edge E:
- busy=1 from after E through edge E+32;
- hi/lo updated at edge E+32;
- done=1 for exactly the cycle following E+32, with busy=0 in that cycle.
REQ-007 hi/lo SHALL be unchanged from accept until the final write (no partial results visible).
REQ-008 start while in MUL or DIV SHALL be ignored.
REQ-009 stall SHALL equal busy AND (hilo_rd OR start), combinationally.
REQ-010 flush in MUL or DIV SHALL return the FSM to IDLE at the next edge, leave hi/lo unchanged, and suppress done.
REQ-011 flush=1 together with start=1 in IDLE SHALL suppress the start, including MTHI/MTLO writes.
REQ-012 The counter SHALL count 0..31 with no wrap into a 33rd iteration; the final iteration is counter=31.
REQ-013 Operands SHALL be latched at accept; later srca/srcb changes SHALL NOT affect the result.

Reset
REQ-014 reset=0 SHALL immediately force:
- FSM to IDLE, counter and working register to 0;
- hi=0, lo=0, busy=0, done=0.
This SHALL hold even mid-operation.
REQ-015 After reset deassertion, the first start SHALL be accepted at the first rising edge with reset=1.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- MULTU srca=32'hFFFF_FFFF, srcb=32'hFFFF_FFFF -> at E+32, hi=32'hFFFF_FFFE, lo=32'h0000_0001; done one cycle; busy exactly 32 cycles.
- DIVU srca=100, srcb=7 -> lo=14, hi=2; DIVU srca=5, srcb=0 -> lo=32'hFFFF_FFFF, hi=5.
- MTHI 32'hDEAD_BEEF then MTLO 32'h1234_5678 in consecutive IDLE cycles -> hi=32'hDEAD_BEEF, lo=32'h1234_5678, busy never set, no done.
- MULTU in progress with hilo_rd=1 -> stall=1 every busy cycle, stall=0 in done cycle; start during busy ignored, result unchanged.
- flush at iteration 10 of DIVU (prior hi=3, lo=4) -> IDLE next cycle, hi=3, lo=4, no done; reset=0 at iteration 20 of MULTU -> hi=lo=0, busy=0 asynchronously.
